// File: rtl/phys_reg_free_list_pkg.sv
// Shared rename-stage definitions: physical tag geometry, rename width and
// the tag type used by the free list, remap file and register rename.
package phys_reg_free_list_pkg;

  localparam int TAG_W        = 6;
  localparam int NUM_PREGS    = 64;
  localparam int NUM_AREGS    = 15;
  localparam int RENAME_WIDTH = 3;

  typedef logic [TAG_W-1:0] preg_tag_t;

  // Destination field of a renamed micro-op.
  typedef struct packed {
    logic      valid;
    logic [3:0] arch_dst;
    preg_tag_t phys_dst;
  } uop_dst_t;

  // Bits needed to hold a popcount of a w-bit slot mask.
  function automatic int slot_cnt_w(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/phys_reg_free_list_slot_prefix_offset.sv
// Per-slot exclusive prefix count of a valid mask, plus its total popcount.
// Packs the active slots of a rename/commit group onto consecutive FIFO entries.
module slot_prefix_offset #(
  parameter int WIDTH = 3,
  parameter int CNT_W = 2
) (
  input  logic [WIDTH-1:0]            valid,
  output logic [WIDTH-1:0][CNT_W-1:0] offset,
  output logic [CNT_W-1:0]            total
);

  logic [CNT_W-1:0] acc;

  always_comb begin
    acc    = '0;
    offset = '0;
    for (int i = 0; i < WIDTH; i++) begin
      offset[i] = acc;
      acc       = acc + CNT_W'(valid[i]);
    end
    total = acc;
  end

endmodule

// File: rtl/phys_reg_free_list.sv
// Circular FIFO of unmapped physical register tags. Rename pops up to WIDTH
// tags per cycle (all-or-nothing), commit pushes up to WIDTH tags per cycle.
module phys_reg_free_list #(
  parameter int NUM_PREGS = phys_reg_free_list_pkg::NUM_PREGS,
  parameter int NUM_AREGS = phys_reg_free_list_pkg::NUM_AREGS,
  parameter int TAG_W     = phys_reg_free_list_pkg::TAG_W,
  parameter int WIDTH     = phys_reg_free_list_pkg::RENAME_WIDTH
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [WIDTH-1:0]            alloc_req_i,
  output logic                        alloc_grant_o,
  output logic [WIDTH-1:0][TAG_W-1:0] alloc_tags_o,
  input  logic [WIDTH-1:0]            free_valid_i,
  input  logic [WIDTH-1:0][TAG_W-1:0] free_tags_i,
  output logic [TAG_W:0]              free_count_o,
  output logic                        empty_o,
  output logic                        overflow_o
);
  import phys_reg_free_list_pkg::*;

  localparam int CNT_W     = slot_cnt_w(WIDTH);
  localparam int INIT_FREE = NUM_PREGS - NUM_AREGS;

  logic [TAG_W-1:0] storage [NUM_PREGS];
  logic [TAG_W-1:0] head_reg, head_next;
  logic [TAG_W-1:0] tail_reg, tail_next;
  logic [TAG_W:0]   count_reg, count_next;
  logic             overflow_reg;

  logic [WIDTH-1:0][CNT_W-1:0] alloc_off, free_off;
  logic [CNT_W-1:0]            n_req, n_free;
  logic                        grant;
  logic [TAG_W:0]              granted, count_sum;
  logic                        ovf_now;

  slot_prefix_offset #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_alloc_off (
    .valid  (alloc_req_i),
    .offset (alloc_off),
    .total  (n_req)
  );

  slot_prefix_offset #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_free_off (
    .valid  (free_valid_i),
    .offset (free_off),
    .total  (n_free)
  );

  // Grant looks only at the registered count, so same-cycle releases never feed it.
  assign grant = (n_req != '0) && (count_reg >= (TAG_W+1)'(n_req)) && !rst;

  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_read
      assign alloc_tags_o[gi] = (grant && alloc_req_i[gi])
                              ? storage[head_reg + TAG_W'(alloc_off[gi])]
                              : '0;
    end
  endgenerate

  always_comb begin
    granted    = grant ? (TAG_W+1)'(n_req) : '0;
    count_sum  = count_reg - granted + (TAG_W+1)'(n_free);
    ovf_now    = count_sum > (TAG_W+1)'(NUM_PREGS);
    head_next  = head_reg + TAG_W'(granted);
    tail_next  = tail_reg;
    count_next = count_sum;
    // An overflowing release is dropped whole; the allocation still retires.
    if (ovf_now) begin
      count_next = count_reg - granted;
    end else begin
      tail_next = tail_reg + TAG_W'(n_free);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_reg     <= '0;
      tail_reg     <= TAG_W'(INIT_FREE);
      count_reg    <= (TAG_W+1)'(INIT_FREE);
      overflow_reg <= 1'b0;
      for (int i = 0; i < NUM_PREGS; i++) begin
        storage[i] <= (i < INIT_FREE) ? TAG_W'(NUM_AREGS + i) : '0;
      end
    end else begin
      head_reg     <= head_next;
      tail_reg     <= tail_next;
      count_reg    <= count_next;
      overflow_reg <= overflow_reg | ovf_now;
      if (!ovf_now) begin
        for (int s = 0; s < WIDTH; s++) begin
          if (free_valid_i[s]) begin
            storage[tail_reg + TAG_W'(free_off[s])] <= free_tags_i[s];
          end
        end
      end
    end
  end

  assign alloc_grant_o = grant;
  assign free_count_o  = count_reg;
  assign empty_o       = (count_reg == '0);
  assign overflow_o    = overflow_reg;

endmodule

// File: tb/tb_phys_reg_free_list.sv
// Directed bench for phys_reg_free_list: reset image, grouped allocation,
// stall/empty, same-cycle release, pointer wrap and sticky overflow.
module tb_phys_reg_free_list;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [2:0]      req = '0;
    logic [2:0]      fv  = '0;
    logic [2:0][5:0] ftags = '0;
    logic [2:0][5:0] atags;
    logic            grant;
    logic [6:0]      cnt;
    logic            empty;
    logic            ovf;

    int checks   = 0;
    int failures = 0;

    logic            s_grant;
    logic [2:0][5:0] s_tags;
    logic [5:0]      q [$];
    logic [5:0]      e;
    logic [5:0]      nt [3];

    always #5 clk = ~clk;

    phys_reg_free_list dut (
        .clk           (clk),
        .rst           (rst),
        .alloc_req_i   (req),
        .alloc_grant_o (grant),
        .alloc_tags_o  (atags),
        .free_valid_i  (fv),
        .free_tags_i   (ftags),
        .free_count_o  (cnt),
        .empty_o       (empty),
        .overflow_o    (ovf)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end else begin
            $display("PASS %s observed=%0d", tag, obs);
        end
    endtask

    // One clock: drive, sample combinational outputs at the falling edge,
    // then return #1 after the rising edge for registered checks.
    task automatic cyc(input logic [2:0] r, input logic [2:0] v,
                       input logic [5:0] t0, input logic [5:0] t1, input logic [5:0] t2);
        req = r;
        fv  = v;
        ftags[0] = t0;
        ftags[1] = t1;
        ftags[2] = t2;
        @(negedge clk);
        s_grant = grant;
        s_tags  = atags;
        @(posedge clk);
        #1;
        req = '0;
        fv  = '0;
    endtask

    initial begin
        #100000;
        failures++;
        $error("FAIL timeout: bench did not complete within the wait limit");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        // Reset holds off grants even with a full request and release present.
        cyc(3'b111, 3'b111, 6'd1, 6'd2, 6'd3);
        chk("rst_grant", s_grant, 1'b0);
        chk("rst_tags", s_tags, 18'd0);
        cyc(3'b111, 3'b000, 6'd0, 6'd0, 6'd0);
        rst = 1'b0;
        chk("rst_count", cnt, 7'd49);
        chk("rst_empty", empty, 1'b0);
        chk("rst_ovf", ovf, 1'b0);

        // Full group after reset.
        cyc(3'b111, 3'b000, 6'd0, 6'd0, 6'd0);
        chk("g111_grant", s_grant, 1'b1);
        chk("g111_t0", s_tags[0], 6'd15);
        chk("g111_t1", s_tags[1], 6'd16);
        chk("g111_t2", s_tags[2], 6'd17);
        chk("g111_count", cnt, 7'd46);

        // Zero-request cycle changes nothing.
        cyc(3'b000, 3'b000, 6'd0, 6'd0, 6'd0);
        chk("idle_grant", s_grant, 1'b0);
        chk("idle_count", cnt, 7'd46);

        // Sparse request packs onto consecutive tags.
        rst = 1'b1;
        cyc(3'b000, 3'b000, 6'd0, 6'd0, 6'd0);
        rst = 1'b0;
        cyc(3'b101, 3'b000, 6'd0, 6'd0, 6'd0);
        chk("g101_grant", s_grant, 1'b1);
        chk("g101_t0", s_tags[0], 6'd15);
        chk("g101_t1", s_tags[1], 6'd0);
        chk("g101_t2", s_tags[2], 6'd16);
        chk("g101_count", cnt, 7'd47);
        cyc(3'b010, 3'b000, 6'd0, 6'd0, 6'd0);
        chk("g010_t0", s_tags[0], 6'd0);
        chk("g010_t1", s_tags[1], 6'd17);
        chk("g010_t2", s_tags[2], 6'd0);

        // Drain to 2 free, then an oversize group stalls.
        for (int k = 0; k < 14; k++) cyc(3'b111, 3'b000, 6'd0, 6'd0, 6'd0);
        cyc(3'b011, 3'b000, 6'd0, 6'd0, 6'd0);
        chk("drain_count", cnt, 7'd2);
        cyc(3'b111, 3'b000, 6'd0, 6'd0, 6'd0);
        chk("stall_grant", s_grant, 1'b0);
        chk("stall_tags", s_tags, 18'd0);
        chk("stall_count", cnt, 7'd2);
        cyc(3'b011, 3'b000, 6'd0, 6'd0, 6'd0);
        chk("last2_grant", s_grant, 1'b1);
        chk("last2_t0", s_tags[0], 6'd62);
        chk("last2_t1", s_tags[1], 6'd63);
        chk("last2_t2", s_tags[2], 6'd0);
        chk("last2_count", cnt, 7'd0);
        chk("last2_empty", empty, 1'b1);

        // Empty: a same-cycle release is not allocatable until the next cycle.
        cyc(3'b001, 3'b001, 6'd5, 6'd0, 6'd0);
        chk("empty_grant", s_grant, 1'b0);
        chk("empty_tags", s_tags, 18'd0);
        chk("refill_count", cnt, 7'd1);
        cyc(3'b001, 3'b000, 6'd0, 6'd0, 6'd0);
        chk("refill_grant", s_grant, 1'b1);
        chk("refill_tag", s_tags[0], 6'd5);
        chk("refill_count0", cnt, 7'd0);

        // Wrap: paired 3-wide alloc/release carries head and tail past 63.
        cyc(3'b000, 3'b111, 6'd40, 6'd41, 6'd42);
        q.push_back(6'd40);
        q.push_back(6'd41);
        q.push_back(6'd42);
        for (int k = 0; k < 25; k++) begin
            for (int j = 0; j < 3; j++) nt[j] = 6'((k * 3 + j) * 5 + 1);
            cyc(3'b111, 3'b111, nt[0], nt[1], nt[2]);
            chk("wrap_grant", s_grant, 1'b1);
            for (int j = 0; j < 3; j++) begin
                e = q.pop_front();
                chk("wrap_tag", s_tags[j], e);
            end
            for (int j = 0; j < 3; j++) q.push_back(nt[j]);
            chk("wrap_count", cnt, 7'd3);
        end

        // Fill to 64, then overflow is sticky and drops the release.
        for (int k = 0; k < 20; k++) cyc(3'b000, 3'b111, 6'd1, 6'd2, 6'd3);
        chk("fill_count63", cnt, 7'd63);
        cyc(3'b000, 3'b001, 6'd9, 6'd0, 6'd0);
        chk("full_count", cnt, 7'd64);
        chk("full_ovf", ovf, 1'b0);
        cyc(3'b000, 3'b001, 6'd10, 6'd0, 6'd0);
        chk("ovf_set", ovf, 1'b1);
        chk("ovf_count", cnt, 7'd64);
        cyc(3'b001, 3'b111, 6'd11, 6'd12, 6'd13);
        e = q.pop_front();
        chk("ovf_alloc_grant", s_grant, 1'b1);
        chk("ovf_alloc_tag", s_tags[0], e);
        chk("ovf_alloc_count", cnt, 7'd63);
        chk("ovf_sticky", ovf, 1'b1);

        // Reset mid-operation restores the reset image.
        rst = 1'b1;
        cyc(3'b111, 3'b111, 6'd1, 6'd2, 6'd3);
        chk("rst2_grant", s_grant, 1'b0);
        rst = 1'b0;
        chk("rst2_count", cnt, 7'd49);
        chk("rst2_ovf", ovf, 1'b0);
        cyc(3'b111, 3'b000, 6'd0, 6'd0, 6'd0);
        chk("rst2_t0", s_tags[0], 6'd15);
        chk("rst2_t1", s_tags[1], 6'd16);
        chk("rst2_t2", s_tags[2], 6'd17);
        chk("rst2_count46", cnt, 7'd46);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/phys_reg_free_list.md
Name: phys_reg_free_list

Overview:
- Allocator for the physical register tag pool consumed by register_rename and remap_file.
- Holds every unmapped 6-bit physical tag in a circular FIFO.
- Rename takes up to 3 tags per cycle; commit returns up to 3 tags per cycle.
- Asserts stall to rename when the pool cannot cover the full group request. Allocation is all-or-nothing per group.

Parameters:
- NUM_PREGS, 64, physical registers; FIFO depth.
- NUM_AREGS, 15, architectural registers identity-mapped at reset (tags 0..14 not free).
- TAG_W, 6, tag width, log2(NUM_PREGS).
- WIDTH, 3, rename/commit slots per cycle.

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  reset, synchronous, active-high
- alloc_req_i  in  WIDTH  per-slot request, slot i needs a destination tag
- alloc_grant_o  out  1  group granted this cycle (combinational)
- alloc_tags_o  out  WIDTH x TAG_W  tag for each requesting slot; 0 for non-requesting slots
- free_valid_i  in  WIDTH  per-slot release valid from commit
- free_tags_i  in  WIDTH x TAG_W  tags being released
- free_count_o  out  TAG_W+1  registered count of free tags
- empty_o  out  1  free_count_o == 0
- overflow_o  out  1  sticky error flag: a release would exceed NUM_PREGS entries

Behaviour:
- State:
  - storage[0..NUM_PREGS-1] of TAG_W bits.
  - head and tail, TAG_W bits each; they wrap modulo 64 by natural overflow.
  - count, TAG_W+1 bits.
- Reset (rst high at an edge):
  - storage[i] = NUM_AREGS + i for i = 0..48; other entries are 0.
  - head = 0, tail = 49, count = 49, overflow_o = 0.
  - While rst is high, alloc_grant_o = 0 and alloc_tags_o = 0, regardless of other inputs.
- Allocation, combinational in the request cycle:
  - n_req = popcount(alloc_req_i).
  - alloc_grant_o = (n_req != 0) && (count >= n_req) && !rst.
  - Requesting slot i takes offset k_i = number of requesting slots below i.
  - alloc_tags_o[i] = storage[head + k_i] when alloc_req_i[i] is set and the group is granted; otherwise 0.
  - Tags are valid in the same cycle. On the next edge, if granted, head += n_req.
  - Not granted: head unchanged, all tags 0. Rename must hold and re-present the request.
  - Zero-request cycle: grant 0, no state change.
- Release, on the edge:
  - n_free = popcount(free_valid_i).
  - Valid slot i writes storage[tail + j_i] = free_tags_i[i], where j_i = number of valid slots below i.
  - tail += n_free.
  - Any tag value is accepted. Duplicate detection is not performed.
- Count update: count_next = count - (grant ? n_req : 0) + n_free.
- Simultaneous allocate and release:
  - Both apply on the same edge.
  - Tags freed in cycle N are not allocatable before cycle N+1; the grant uses the registered count only.
  - Allocate reads and release writes never alias: write slots sit at tail and beyond, read slots are the first count entries from head.
- Overflow:
  - Triggered if count - granted + n_free > NUM_PREGS.
  - overflow_o sets and holds until rst.
  - The release is dropped in full: tail and count are unchanged by the release, while the allocation still applies.
- Full: count == 64 with no allocation means any further release overflows.
- Empty: count == 0 gives empty_o = 1 and no grant for any nonzero request.
- Wrap: pointer arithmetic is modulo 64. Slot offsets straddling index 63 to 0 must work.
- Reset mid-operation: rst overrides any simultaneous request or release on that edge. The pool returns to the reset image.

Decomposition:
- Shared package/header, alongside the micro-op field definitions:
  - TAG_W, NUM_PREGS, NUM_AREGS, RENAME_WIDTH.
  - The tag typedef, shared with remap_file and register_rename.
- One sub-module, slot_prefix_offset:
  - Input: a WIDTH-bit valid mask.
  - Outputs: per-slot exclusive prefix count and total popcount.
  - Instantiated twice, once for allocate and once for release.

Test Plan:
- Reset then alloc_req = 3'b111 → grant 1, tags {15,16,17} in slots 0,1,2. Next cycle free_count = 46.
- After reset, alloc_req = 3'b101 → grant 1, slot0 = 15, slot1 = 0, slot2 = 16. Next request 3'b010 → slot1 = 17.
- Drain to count = 2, then req 3'b111 → grant 0, tags all 0, count stays 2. Then req 3'b011 → grant 1, count goes to 0 and empty_o = 1.
- With count = 0, the same cycle has req 3'b001 and free_valid 3'b001 with tag 5 → grant 0. Next cycle count = 1 and req 3'b001 → tag 5.
- Cycle 64+ alloc/release pairs so head and tail wrap past 63 → FIFO order is preserved and count stays constant.
- Free everything until count = 64, then release 1 more → overflow_o = 1 (sticky), count stays 64. Then rst → count = 49, overflow_o = 0.
